cp0_exc_ctrl: RTL

Exception/interrupt sequencer for the multicycle MIPS54 core. It sits between the main control FSM and the CP0 register file.
- At each instruction boundary it evaluates trap requests (syscall, break, taken teq), eret and external interrupts against the CP0 Status word.
- It drives the CP0 exception/eret strobes with the Cause word and saved PC.
- It stalls the core and then redirects the PC to the handler or to EPC.

---
 rtl/cp0_exc_ctrl_pkg.sv | 17 +
 rtl/cp0_exc_ctrl_if.sv | 30 +++
 rtl/cp0_exc_ctrl_irq_sync.sv | 16 +
 rtl/cp0_exc_ctrl.sv | 63 ++++++
 4 files changed

// File: rtl/cp0_exc_ctrl_pkg.sv
// cp0_exc_ctrl_pkg: shared CP0 exception constants, Status bit map and sequencer states
package cp0_exc_ctrl_pkg;
    localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0040_0004;
    localparam int ST_IE  = 0;
    localparam int ST_SYS = 1;
    localparam int ST_BRK = 2;
    localparam int ST_TEQ = 3;
    localparam int ST_INT = 4;
    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_BRK = 5'd9;
    localparam logic [4:0] EXC_TEQ = 5'd13;
    typedef enum logic [2:0] {S_IDLE, S_TRAP, S_TREDIR, S_ERET, S_EREDIR} state_t;
    function automatic logic [31:0] make_cause(input logic [4:0] code, input logic [5:0] ip);
        return {16'b0, ip, 3'b0, code, 2'b0};
    endfunction
endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// cp0_exc_ctrl_if: core/CP0 side signals of the exception sequencer
interface cp0_exc_ctrl_if #(parameter int N_IRQ = 6);
    logic              instr_done;
    logic              is_syscall;
    logic              is_break;
    logic              is_teq_taken;
    logic              is_eret;
    logic [31:0]       pc;
    logic [31:0]       next_pc;
    logic [N_IRQ-1:0]  irq;
    logic [31:0]       status;
    logic [31:0]       epc;
    logic              exception;
    logic              eret;
    logic [31:0]       cause;
    logic [31:0]       exc_pc;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              stall;
    modport master (
        output instr_done, is_syscall, is_break, is_teq_taken, is_eret,
        output pc, next_pc, irq, status, epc,
        input  exception, eret, cause, exc_pc, redirect_valid, redirect_pc, stall
    );
    modport slave (
        input  instr_done, is_syscall, is_break, is_teq_taken, is_eret,
        input  pc, next_pc, irq, status, epc,
        output exception, eret, cause, exc_pc, redirect_valid, redirect_pc, stall
    );
endinterface

// File: rtl/cp0_exc_ctrl_irq_sync.sv
// cp0_exc_ctrl_irq_sync: multi-flop synchronizer for the external interrupt lines
module cp0_exc_ctrl_irq_sync #(
    parameter int N      = 6,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    logic [STAGES*N-1:0] sh;
    always_ff @(posedge clk or posedge rst)
        if (rst) sh <= '0;
        else     sh <= {sh[(STAGES-1)*N-1:0], d};
    assign q = sh[STAGES*N-1 -: N];
endmodule

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: boundary trap/eret/interrupt sequencer driving CP0 strobes and PC redirect
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
    parameter int          SYNC_STAGES  = 2,
    parameter int          N_IRQ        = 6
) (
    input logic           clk,
    input logic           rst,
    cp0_exc_ctrl_if.slave bus
);
    localparam int IPW = (N_IRQ < 6) ? N_IRQ : 6;
    state_t st, nx;
    logic [N_IRQ-1:0] irq_s;
    logic [5:0] ip;
    logic ie, take_sys, take_brk, take_teq, take_int, sync_trap, trap_go, eret_go;
    logic [4:0] code;
    logic [31:0] cause_q, exc_pc_q;
    wire unused_status = &{1'b0, bus.status[31:5]};
    cp0_exc_ctrl_irq_sync #(.N(N_IRQ), .STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .rst(rst), .d(bus.irq), .q(irq_s)
    );
    always_comb begin
        ip = '0;
        ip[IPW-1:0] = irq_s[IPW-1:0];
    end
    // eret outranks a pending irq; the irq is picked up at the next boundary
    assign ie        = bus.status[ST_IE];
    assign take_sys  = bus.is_syscall   & ie & bus.status[ST_SYS];
    assign take_brk  = bus.is_break     & ie & bus.status[ST_BRK];
    assign take_teq  = bus.is_teq_taken & ie & bus.status[ST_TEQ];
    assign take_int  = ie & bus.status[ST_INT] & |irq_s;
    assign sync_trap = take_sys | take_brk | take_teq;
    assign trap_go   = (st == S_IDLE) & bus.instr_done & (sync_trap | (~bus.is_eret & take_int));
    assign eret_go   = (st == S_IDLE) & bus.instr_done & ~sync_trap & bus.is_eret;
    assign code      = take_sys ? EXC_SYS : take_brk ? EXC_BRK : take_teq ? EXC_TEQ : EXC_INT;
    always_ff @(posedge clk or posedge rst)
        if (rst) st <= S_IDLE;
        else     st <= nx;
    always_comb begin
        nx = (st == S_IDLE)  ? (trap_go ? S_TRAP : eret_go ? S_ERET : S_IDLE) :
             (st == S_TRAP)  ? S_TREDIR :
             (st == S_ERET)  ? S_EREDIR : S_IDLE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cause_q  <= '0;
            exc_pc_q <= '0;
        end else if (trap_go) begin
            cause_q  <= make_cause(code, ip);
            exc_pc_q <= sync_trap ? bus.pc : bus.next_pc;
        end
    always_comb begin
        bus.exception      = st == S_TRAP;
        bus.eret           = st == S_ERET;
        bus.redirect_valid = (st == S_TREDIR) | (st == S_EREDIR);
        bus.redirect_pc    = (st == S_TREDIR) ? HANDLER_ADDR : (st == S_EREDIR) ? bus.epc : '0;
        bus.stall          = (st != S_IDLE) | trap_go | eret_go;
        bus.cause          = cause_q;
        bus.exc_pc         = exc_pc_q;
    end
endmodule
